// File: rtl/tick_gen_if.sv
// rtl/tick_gen_if.sv - command/status bundle between run control and tick_gen
//
// Purpose:
//   Groups the run-control commands and the prescaler status outputs of tick_gen.
//   The controller side uses modport master. tick_gen uses modport slave.
// Parameters:
//   CW       prescaler width, must match tick_gen.CW
// Signals:
//   start    master->slave  start/resume command
//   stop     master->slave  pause command
//   clr      master->slave  clear to IDLE
//   tick     slave->master  1-clk pulse every DIV clks while running
//   running  slave->master  run state is RUN
//   paused   slave->master  run state is PAUSE
//   phase    slave->master  current prescaler value (CW bits)

interface tick_gen_if #(
    parameter int CW = 26
) ();
    logic          start;
    logic          stop;
    logic          clr;
    logic          tick;
    logic          running;
    logic          paused;
    logic [CW-1:0] phase;

    modport master (
        output start,
        output stop,
        output clr,
        input  tick,
        input  running,
        input  paused,
        input  phase
    );

    modport slave (
        input  start,
        input  stop,
        input  clr,
        output tick,
        output running,
        output paused,
        output phase
    );
endinterface

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - run-control prescaler emitting a one-clk tick every DIV clks
//
// Purpose:
//   Divides clk by DIV and emits a single-cycle tick that enables the first
//   stage of the downstream decade counter chain. A three-state run FSM
//   (IDLE/RUN/PAUSE) is driven by start/stop/clr with priority clr > stop > start.
// Parameters:
//   DIV      clk cycles per tick, DIV >= 1
//   CW       prescaler width, 2**CW >= DIV
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   bus      tick_gen_if.slave: start/stop/clr in; tick/running/paused/phase out
// Configuration:
//   TICK_BTN_SYNC_EN  when defined, each command passes through a 2-FF
//                     synchronizer plus rising-edge detector, so any-length
//                     level yields one command, acted on at the 3rd clk edge.
//                     When undefined, commands act on every edge they are high.

module tick_gen #(
    parameter int DIV = 50_000_000,
    parameter int CW  = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    tick_gen_if.slave  bus
);

    // Terminal prescaler value; comparing against it (instead of relying on
    // a 2**CW rollover) keeps the wrap exact for any DIV.
    localparam logic [CW-1:0] PRE_MAX = CW'(DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    logic start_cmd;
    logic stop_cmd;
    logic clr_cmd;

`ifdef TICK_BTN_SYNC_EN
    // Bit order within the command vectors: {clr, stop, start}.
    logic [2:0] cmd_raw;
    logic [2:0] sync1_q;
    logic [2:0] sync2_q;
    logic [2:0] sync3_q;
    logic [2:0] cmd_rise;

    assign cmd_raw = {bus.clr, bus.stop, bus.start};

    // sync1/sync2 form the metastability chain; sync3 is the delayed copy
    // used only for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
            sync3_q <= 3'b000;
        end else begin
            sync1_q <= cmd_raw;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign cmd_rise = sync2_q & ~sync3_q;

    assign clr_cmd   = cmd_rise[2];
    assign stop_cmd  = cmd_rise[1];
    assign start_cmd = cmd_rise[0];
`else
    assign start_cmd = bus.start;
    assign stop_cmd  = bus.stop;
    assign clr_cmd   = bus.clr;
`endif

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] pre_q;
    logic [CW-1:0] pre_d;
    logic          tick_q;
    logic          tick_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pre_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            tick_q  <= tick_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        tick_d  = 1'b0;

        if (clr_cmd) begin
            state_d = ST_IDLE;
            pre_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_cmd) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // stop wins over a tick that would otherwise fire this edge;
                    // pre is frozen so a later resume keeps the phase.
                    if (stop_cmd) begin
                        state_d = ST_PAUSE;
                    end else if (pre_q == PRE_MAX) begin
                        pre_d  = '0;
                        tick_d = 1'b1;
                    end else begin
                        pre_d = pre_q + CW'(1);
                    end
                end
                ST_PAUSE: begin
                    if (start_cmd) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    pre_d   = '0;
                end
            endcase
        end
    end

    assign bus.tick    = tick_q;
    assign bus.running = (state_q == ST_RUN);
    assign bus.paused  = (state_q == ST_PAUSE);
    assign bus.phase   = pre_q;

endmodule

// File: tb/tb_tick_gen.sv
// tb/tb_tick_gen.sv - scoreboard bench for tick_gen with DIV=4, CW=3

module tb_tick_gen;

    localparam int DIV = 4;
    localparam int CW  = 3;

    typedef struct packed {
        logic          tick;
        logic          running;
        logic          paused;
        logic [CW-1:0] phase;
    } obs_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    tick_gen_if #(.CW(CW)) bus ();

    tick_gen #(.DIV(DIV), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    obs_t sb[$];

    // Reference model: mode 0=IDLE 1=RUN 2=PAUSE; m_count counts edges spent
    // prescaling since the last clear, so phase is m_count mod DIV and a tick
    // marks each edge that completes a multiple of DIV.
    int   m_mode  = 0;
    int   m_count = 0;
    logic m_tick  = 1'b0;
    logic [2:0] h1 = 3'b000;
    logic [2:0] h2 = 3'b000;
    logic [2:0] h3 = 3'b000;

    task automatic check_obs(input string name, input obs_t act, input obs_t exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s @%0t: got tick=%0b running=%0b paused=%0b phase=%0d, expected tick=%0b running=%0b paused=%0b phase=%0d",
                     name, $time, act.tick, act.running, act.paused, act.phase,
                     exp.tick, exp.running, exp.paused, exp.phase);
        end
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        o.tick    = m_tick;
        o.running = (m_mode == 1);
        o.paused  = (m_mode == 2);
        o.phase   = CW'(m_count % DIV);
        return o;
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_count = 0;
        m_tick  = 1'b0;
        h1 = 3'b000;
        h2 = 3'b000;
        h3 = 3'b000;
    endtask

    // Advance the model by one clock edge with raw inputs {c,p,s}.
    task automatic model_step(input logic s, input logic p, input logic c);
        logic [2:0] eff;
`ifdef TICK_BTN_SYNC_EN
        // A level first sampled at edge n-2 becomes a command at edge n,
        // once per rising transition.
        eff = h2 & ~h3;
        h3 = h2;
        h2 = h1;
        h1 = {c, p, s};
`else
        eff = {c, p, s};
`endif
        m_tick = 1'b0;
        if (eff[2]) begin
            m_mode  = 0;
            m_count = 0;
        end else if (m_mode == 1) begin
            if (eff[1]) begin
                m_mode = 2;
            end else begin
                m_count++;
                m_tick = ((m_count % DIV) == 0);
            end
        end else if (eff[0]) begin
            m_mode = 1;
        end
    endtask

    task automatic cycle(input logic s, input logic p, input logic c);
        @(negedge clk);
        bus.start = s;
        bus.stop  = p;
        bus.clr   = c;
        model_step(s, p, c);
        sb.push_back(model_obs());
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
    endtask

    // Run until the model is in RUN at phase k; bounded so it cannot hang.
    task automatic run_to_phase(input int k);
        for (int i = 0; i < 4 * DIV + 8; i++) begin
            if (m_mode == 1 && (m_count % DIV) == k) break;
            cycle(1'b0, 1'b0, 1'b0);
        end
    endtask

    // Drop rst_n between edges and check the outputs clear with no clock edge.
    task automatic do_reset();
        obs_t act;
        @(posedge clk);
        #2;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.clr   = 1'b0;
        #1;
        act = {bus.tick, bus.running, bus.paused, bus.phase};
        check_obs("async_reset", act, '0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: every output cycle after reset is compared against the next
    // expected entry pushed by the stimulus side.
    initial begin
        obs_t act;
        obs_t exp;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && sb.size() > 0) begin
                exp = sb.pop_front();
                act = {bus.tick, bus.running, bus.paused, bus.phase};
                check_obs("scoreboard", act, exp);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t act;
        logic s;
        logic p;
        logic c;

        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.clr   = 1'b0;
        #1;
        act = {bus.tick, bus.running, bus.paused, bus.phase};
        check_obs("reset_at_t0", act, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Start pulse and free run through several tick periods.
        idle_cycles(2);
        cycle(1'b1, 1'b0, 1'b0);
        idle_cycles(14);

        // Pause at phase 2, hold, resume.
        run_to_phase(2);
        cycle(1'b0, 1'b1, 1'b0);
        idle_cycles(4);
        cycle(1'b1, 1'b0, 1'b0);
        idle_cycles(6);

        // stop and clr together at phase 3.
        run_to_phase(3);
        cycle(1'b0, 1'b1, 1'b1);
        idle_cycles(4);

        // start+stop together in IDLE, RUN and PAUSE.
        cycle(1'b1, 1'b1, 1'b0);
        idle_cycles(5);
        cycle(1'b1, 1'b1, 1'b0);
        idle_cycles(4);
        cycle(1'b1, 1'b1, 1'b0);
        idle_cycles(6);

        // Held clr keeps IDLE even with start asserted.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b1);
        idle_cycles(4);

        // Async reset mid-RUN, then idle until start.
        cycle(1'b1, 1'b0, 1'b0);
        idle_cycles(6);
        do_reset();
        idle_cycles(5);

        // start held high for 10 clks from IDLE.
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0);
        idle_cycles(6);

        // Randomised command mix with occasional resets.
        for (int i = 0; i < 2000; i++) begin
            if (i % 500 == 250) begin
                idle_cycles(1);
                do_reset();
            end
            s = ($urandom_range(0, 99) < 15);
            p = ($urandom_range(0, 99) < 10);
            c = ($urandom_range(0, 99) < 3);
            cycle(s, p, c);
        end

        idle_cycles(4);
        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (sb.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
